wb_spi_flash_cache: RTL
=======================

Name: wb_spi_flash_cache

Overview:
- Read-only Wishbone slave serving instruction/data fetches from an external SPI NOR flash, configurable in address width, read command, dummy cycles and SCK divider.
- Holds a one-line prefetch buffer of LINE_WORDS 32-bit words; hits ack in one cycle, misses fetch a whole aligned line in a single SPI transaction.
- Sits between the core's instruction bus and the SPI flash pins; the flash is the only device on its SPI bus.

Parameters:
- ADDR_BITS, 24, flash address bits sent after the command (24 or 32).
- READ_CMD, 8'h03, SPI read opcode (8'h0B with DUMMY_CYCLES=8 for fast read).
- DUMMY_CYCLES, 0, SCK cycles between address and data, MOSI driven 0.
- CLK_DIV, 1, clk cycles per SCK half-period (>=1).
- LINE_WORDS, 4, words per line; power of two, 1..8. LW_BITS = log2(LINE_WORDS).

Ports:
- clk  in  1  system clock; all logic is posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- adr_i  in  32  Wishbone byte address; bits [1:0] ignored.
- dat_i  in  32  Wishbone write data; unused.
- we_i  in  1  write enable.
- sel_i  in  4  byte select; ignored, a full word is always returned.
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle.
- ack_o  out  1  registered one-cycle acknowledge.
- err_o  out  1  registered one-cycle error, raised for writes.
- dat_o  out  32  read data; valid only while ack_o=1, 0 otherwise.
- inv_i  in  1  invalidate line buffer (single-cycle pulse).
- spi_sck_o  out  1  SCK, mode 0 (idle low).
- spi_cs_o  out  1  chip select, active-low.
- spi_mosi_o  out  1  serial out.
- spi_miso_i  in  1  serial in.

Behaviour:
Reset values:
- ack_o=0, err_o=0, dat_o=0.
- spi_cs_o=1, spi_sck_o=0, spi_mosi_o=0.
- line_valid=0, state=IDLE.
- Reset mid-transaction aborts at once: CS high, SCK low, line_valid=0.

Request acceptance:
- A request is stb_i&cyc_i seen in IDLE while ack_o=0 and err_o=0, so one request never gets two responses.
- Write (we_i=1): err_o=1 on the next cycle; no SPI activity.
- Read hit: line_valid and adr_i[ADDR_BITS-1:2+LW_BITS]==tag. ack_o=1 on the next cycle; dat_o = line[adr_i[2+:LW_BITS]].
- Read miss: latch the tag and enter XFER.

Line fetch:
- The fetch streams N = 8 + ADDR_BITS + DUMMY_CYCLES + 32*LINE_WORDS bits.
- Bit order on MOSI: READ_CMD MSB-first, then {tag, LW_BITS+2 zeros} MSB-first, then zeros.

SPI timing (request sampled at cycle T):
- T+1: CS low and MOSI = bit 0.
- SCK toggles every CLK_DIV clks; the k-th rising edge is at T+1+(2k+1)*CLK_DIV.
- MOSI changes only on falling edges.
- MISO is sampled on the clk where SCK rises.
- After the final falling edge (T+1+2N*CLK_DIV), CS goes high.
- line_valid is set, state=RESP, then ack_o=1 at T+2+2N*CLK_DIV with the requested word.
- Defaults give N=160 and ack at T+322.

Data assembly:
- Flash bytes b0..b3 at word address A..A+3 form word {b3,b2,b1,b0}.
- Words fill the line in increasing address order.

States: IDLE -> XFER -> RESP -> IDLE.
- RESP lasts one cycle.
- CS stays high for at least one clk before the next fetch.

Abort and invalidate:
- If stb_i or cyc_i drops during XFER, the fetch still completes and fills the line.
- In that case no ack is issued in RESP.
- inv_i clears line_valid; inv_i in the same cycle as a fill completion wins, leaving the line invalid.
- In that collision case the pending ack is still returned with the fetched data.

Counters: the bit counter is sized $clog2(N+1); the divider is sized $clog2(CLK_DIV+1).

Decomposition:
- Package wb_spi_pkg: state enum (IDLE/XFER/RESP), READ_CMD defaults (8'h03, 8'h0B), helper function for N.
- Sub-module spi_bit_engine: owns the SCK divider, bit counter, MOSI shift and MISO sample strobe.
  - Inputs: start, total bits, MOSI preload.
  - Outputs: sample_stb, bit_idx, done.
- The top level holds the line buffer, tag, Wishbone handshake and FSM.

Test Plan:
1. Reset, with rst_n low for 3 clks -> all outputs at reset values; no SCK toggling for 20 clks after release.
2. Defaults, read 0x000104 with flash holding byte value = address[7:0] -> MOSI stream 0x03,0x00,0x01,0x00; ack at T+322; dat_o=0x07060504; CS high 1 cycle before ack.
3. Read 0x00010C immediately after scenario 2 -> hit, ack at T+1, dat_o=0x0F0E0D0C, CS stays high.
4. Read 0x000110 -> miss, new fetch from 0x000110, dat_o=0x13121110. Then write to 0x000110 -> err_o pulse at T+1, ack_o=0, no SPI activity.
5. inv_i pulse, then read 0x000114 -> re-fetch occurs (miss) and returns 0x17161514. Separately, assert rst_n low at bit 50 of a fetch -> CS=1 at once; the next read is a miss.
6. CLK_DIV=2, READ_CMD=8'h0B, DUMMY_CYCLES=8, LINE_WORDS=1, read 0x000020.
   - N=72, ack at T+290.
   - SCK period 4 clks; 8 zero MOSI bits after the address.
   - dat_o=0x23222120.

Source files
------------

// File: rtl/wb_spi_pkg.sv
// Shared types and constants for the Wishbone SPI flash line cache.
package wb_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    // Total SCK cycles in one line fetch: opcode, address, dummy, line data.
    function automatic int fetch_bits(input int addr_bits, input int dummy_cycles,
                                      input int line_words);
        return 8 + addr_bits + dummy_cycles + 32 * line_words;
    endfunction

endpackage

// File: rtl/wb_spi_flash_cache_engine.sv
// SPI mode-0 bit engine: SCK divider, bit counter, MOSI header shifter and
// MISO sample strobe for one flash read transaction.
module spi_bit_engine #(
    parameter int CNT_W   = 8,
    parameter int DIV_W   = 1,
    parameter int HDR_W   = 32,
    parameter int CLK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] total_bits,
    input  logic [HDR_W-1:0] mosi_preload,
    output logic             sample_stb,
    output logic [CNT_W-1:0] bit_idx,
    output logic             done,
    output logic             spi_sck_o,
    output logic             spi_cs_o,
    output logic             spi_mosi_o
);

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

    logic             cs_q, cs_d;
    logic             sck_q, sck_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic [HDR_W-1:0] sh_q, sh_d;
    logic             tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q  <= 1'b1;
            sck_q <= 1'b0;
            div_q <= '0;
            bit_q <= '0;
            sh_q  <= '0;
        end else begin
            cs_q  <= cs_d;
            sck_q <= sck_d;
            div_q <= div_d;
            bit_q <= bit_d;
            sh_q  <= sh_d;
        end
    end

    assign tick = !cs_q && (div_q == '0);

    always_comb begin
        cs_d       = cs_q;
        sck_d      = sck_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        sample_stb = 1'b0;
        done       = 1'b0;
        if (start) begin
            cs_d  = 1'b0;
            sck_d = 1'b0;
            div_d = DIV_RELOAD;
            bit_d = '0;
            sh_d  = mosi_preload;
        end else if (tick) begin
            div_d = DIV_RELOAD;
            sck_d = !sck_q;
            if (!sck_q) begin
                sample_stb = 1'b1;
            end else begin
                // Falling edge: advance MOSI; zeros follow the header.
                sh_d = {sh_q[HDR_W-2:0], 1'b0};
                if (bit_q == total_bits - CNT_W'(1)) begin
                    done = 1'b1;
                    cs_d = 1'b1;
                end else begin
                    bit_d = bit_q + CNT_W'(1);
                end
            end
        end else if (!cs_q) begin
            div_d = div_q - DIV_W'(1);
        end
    end

    assign bit_idx    = bit_q;
    assign spi_sck_o  = sck_q;
    assign spi_cs_o   = cs_q;
    assign spi_mosi_o = sh_q[HDR_W-1];

endmodule

// File: rtl/wb_spi_flash_cache.sv
// Read-only Wishbone slave fetching aligned lines from SPI NOR flash into a
// single-line prefetch buffer.
//
// state | meaning
// IDLE  | accept requests; hits and write errors answered next cycle
// XFER  | line fetch in progress on the SPI bus
// RESP  | line filled, CS high; ack if the requester is still waiting
module wb_spi_flash_cache
    import wb_spi_pkg::*;
#(
    parameter int          ADDR_BITS    = 24,
    parameter logic [7:0]  READ_CMD     = CMD_READ,
    parameter int          DUMMY_CYCLES = 0,
    parameter int          CLK_DIV      = 1,
    parameter int          LINE_WORDS   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] dat_o,
    input  logic        inv_i,
    output logic        spi_sck_o,
    output logic        spi_cs_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam int LW_BITS  = $clog2(LINE_WORDS);
    localparam int LW_IDX   = (LW_BITS > 0) ? LW_BITS : 1;
    localparam int SLOTS    = 1 << LW_IDX;
    localparam int TAG_W    = ADDR_BITS - 2 - LW_BITS;
    localparam int N_BITS   = fetch_bits(ADDR_BITS, DUMMY_CYCLES, LINE_WORDS);
    localparam int CNT_W    = $clog2(N_BITS + 1);
    localparam int DIV_W    = $clog2(CLK_DIV + 1);
    localparam int HDR_W    = 8 + ADDR_BITS;
    localparam int DATA_OFS = 8 + ADDR_BITS + DUMMY_CYCLES;

    state_e             state_q, state_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        dat_q, dat_d;
    logic               valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [LW_IDX-1:0]  widx_q, widx_d;
    logic               pend_q, pend_d;
    logic [31:0]        line_q [SLOTS];
    logic [31:0]        line_d [SLOTS];

    logic               start;
    logic               sample_stb;
    logic               done;
    logic [CNT_W-1:0]   bit_idx;
    logic [CNT_W-1:0]   doff;
    logic [LW_IDX-1:0]  fill_word;
    logic [4:0]         fill_bit;
    logic [LW_IDX-1:0]  req_widx;
    logic [TAG_W-1:0]   req_tag;
    logic               req;
    logic               hit;
    logic               unused_in;

    assign unused_in = ^{dat_i, sel_i, adr_i};

    assign req_tag  = adr_i[ADDR_BITS-1 -: TAG_W];
    assign req_widx = LW_IDX'((adr_i >> 2) & 32'(LINE_WORDS - 1));
    assign req      = stb_i && cyc_i && !ack_q && !err_q;
    assign hit      = valid_q && (req_tag == tag_q);

    // Flash bytes arrive MSB-first, lowest address first -> little-endian word.
    assign doff      = bit_idx - CNT_W'(DATA_OFS);
    assign fill_word = LW_IDX'(doff >> 5);
    assign fill_bit  = {doff[4:3], ~doff[2:0]};

    spi_bit_engine #(
        .CNT_W   (CNT_W),
        .DIV_W   (DIV_W),
        .HDR_W   (HDR_W),
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .total_bits   (CNT_W'(N_BITS)),
        .mosi_preload ({READ_CMD, req_tag, {(LW_BITS + 2){1'b0}}}),
        .sample_stb   (sample_stb),
        .bit_idx      (bit_idx),
        .done         (done),
        .spi_sck_o    (spi_sck_o),
        .spi_cs_o     (spi_cs_o),
        .spi_mosi_o   (spi_mosi_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            widx_q  <= '0;
            pend_q  <= 1'b0;
            line_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            widx_q  <= widx_d;
            pend_q  <= pend_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = '0;
        valid_d = valid_q;
        tag_d   = tag_q;
        widx_d  = widx_q;
        pend_d  = pend_q;
        line_d  = line_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (we_i) begin
                        err_d = 1'b1;
                    end else if (hit) begin
                        ack_d = 1'b1;
                        dat_d = line_q[req_widx];
                    end else begin
                        start   = 1'b1;
                        tag_d   = req_tag;
                        widx_d  = req_widx;
                        pend_d  = 1'b1;
                        valid_d = 1'b0;
                        state_d = XFER;
                    end
                end
            end
            XFER: begin
                // A dropped request still fills the line but gets no ack.
                if (!(stb_i && cyc_i)) begin
                    pend_d = 1'b0;
                end
                if (sample_stb && (bit_idx >= CNT_W'(DATA_OFS))) begin
                    line_d[fill_word][fill_bit] = spi_miso_i;
                end
                if (done) begin
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (pend_q) begin
                    ack_d = 1'b1;
                    dat_d = line_q[widx_q];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (inv_i) begin
            valid_d = 1'b0;
        end
    end

    assign ack_o = ack_q;
    assign err_o = err_q;
    assign dat_o = dat_q;

endmodule
